// File: rtl/stamp_counter_multi_pkg.sv
// Shared definitions for the timestamp counter: default increment, the
// capture-channel state encoding and the accumulator width helper.
package stamp_counter_multi_pkg;

  localparam int DEFAULT_INC_NS = 10;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_FULL = 1'b1
  } chan_state_t;

  function automatic int acc_width(input int ts_width, input int frac_width);
    return ts_width + frac_width;
  endfunction

endpackage

// File: rtl/stamp_capture_chan.sv
// One capture channel: latches the stamp on request, holds it until
// acknowledged, and flags requests lost while the slot is occupied.
module stamp_capture_chan
  import stamp_counter_multi_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH = 64
) (
  input  logic                       axi_aclk,
  input  logic                       axi_reset,
  input  logic                       capture_req,
  input  logic                       capture_ack,
  input  logic [TIMESTAMP_WIDTH-1:0] stamp,
  output logic [TIMESTAMP_WIDTH-1:0] capture_data,
  output logic                       capture_valid,
  output logic                       capture_ovf
);

  chan_state_t                state, state_next;
  logic [TIMESTAMP_WIDTH-1:0] data_next;
  logic                       ovf_next;

  // NOTE: state is updated with non-blocking assignments only, so every
  // always_ff in the design samples pre-edge values regardless of order.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state        <= CH_IDLE;
      capture_data <= '0;
      capture_ovf  <= 1'b0;
    end else begin
      state        <= state_next;
      capture_data <= data_next;
      capture_ovf  <= ovf_next;
    end
  end

  // NOTE: every output gets a default before the case, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    data_next  = capture_data;
    ovf_next   = capture_ovf;
    case (state)
      CH_IDLE: begin
        if (capture_req) begin
          state_next = CH_FULL;
          data_next  = stamp;
          ovf_next   = 1'b0;
        end else if (capture_ack) begin
          ovf_next = 1'b0;
        end
      end
      CH_FULL: begin
        if (capture_req) begin
          // Without an ack the first capture wins and the loss is flagged.
          ovf_next = !capture_ack;
          if (capture_ack) data_next = stamp;
        end else if (capture_ack) begin
          state_next = CH_IDLE;
          ovf_next   = 1'b0;
        end
      end
      default: state_next = CH_IDLE;
    endcase
  end

  assign capture_valid = (state == CH_FULL);

endmodule

// File: rtl/stamp_counter_multi.sv
// Free-running fractional-ns timestamp with programmable increment, atomic
// load, signed one-shot adjust and NUM_CHAN independent capture channels.
module stamp_counter_multi
  import stamp_counter_multi_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int FRAC_WIDTH      = 24,
  parameter int INC_INT_WIDTH   = 8,
  parameter logic [INC_INT_WIDTH+FRAC_WIDTH-1:0] INC_DEFAULT = DEFAULT_INC_NS << FRAC_WIDTH,
  parameter int NUM_CHAN        = 4
) (
  input  logic                                axi_aclk,
  input  logic                                axi_reset,
  input  logic                                count_en,
  input  logic                                inc_valid,
  input  logic [INC_INT_WIDTH+FRAC_WIDTH-1:0] inc_value,
  input  logic                                load_valid,
  input  logic [TIMESTAMP_WIDTH-1:0]          load_value,
  input  logic                                adj_valid,
  input  logic [TIMESTAMP_WIDTH-1:0]          adj_value,
  input  logic [NUM_CHAN-1:0]                 capture_req,
  input  logic [NUM_CHAN-1:0]                 capture_ack,
  output logic [TIMESTAMP_WIDTH-1:0]          stamp_counter,
  output logic [NUM_CHAN*TIMESTAMP_WIDTH-1:0] capture_data,
  output logic [NUM_CHAN-1:0]                 capture_valid,
  output logic [NUM_CHAN-1:0]                 capture_ovf
);

  localparam int ACC_W = acc_width(TIMESTAMP_WIDTH, FRAC_WIDTH);
  localparam int INC_W = INC_INT_WIDTH + FRAC_WIDTH;

  logic [ACC_W-1:0] acc, acc_next, inc_term, adj_term;
  logic [INC_W-1:0] inc_reg;

  // Appending zero fraction bits is the sign-extended offset shifted left,
  // reduced modulo the accumulator width.
  always_comb begin
    inc_term = count_en  ? ACC_W'(inc_reg) : '0;
    adj_term = adj_valid ? {adj_value, {FRAC_WIDTH{1'b0}}} : '0;
    if (load_valid) acc_next = {load_value, {FRAC_WIDTH{1'b0}}};
    else            acc_next = acc + inc_term + adj_term;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      acc     <= '0;
      inc_reg <= INC_DEFAULT;
    end else begin
      acc <= acc_next;
      if (inc_valid) inc_reg <= inc_value;
    end
  end

  assign stamp_counter = acc[ACC_W-1 -: TIMESTAMP_WIDTH];

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
    stamp_capture_chan #(
      .TIMESTAMP_WIDTH(TIMESTAMP_WIDTH)
    ) u_chan (
      .axi_aclk     (axi_aclk),
      .axi_reset    (axi_reset),
      .capture_req  (capture_req[i]),
      .capture_ack  (capture_ack[i]),
      .stamp        (stamp_counter),
      .capture_data (capture_data[i*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH]),
      .capture_valid(capture_valid[i]),
      .capture_ovf  (capture_ovf[i])
    );
  end

endmodule

// File: tb/tb_stamp_counter_multi.sv
// Directed and randomized bench for stamp_counter_multi against an
// arithmetic reference model of the accumulator and capture channels.
module tb_stamp_counter_multi;

  localparam int TW = 64;
  localparam int FW = 24;
  localparam int IW = 8;
  localparam int NC = 4;
  localparam int AW = TW + FW;

  logic              axi_aclk = 1'b0;
  logic              axi_reset;
  logic              count_en;
  logic              inc_valid;
  logic [IW+FW-1:0]  inc_value;
  logic              load_valid;
  logic [TW-1:0]     load_value;
  logic              adj_valid;
  logic [TW-1:0]     adj_value;
  logic [NC-1:0]     capture_req;
  logic [NC-1:0]     capture_ack;
  logic [TW-1:0]     stamp_counter;
  logic [NC*TW-1:0]  capture_data;
  logic [NC-1:0]     capture_valid;
  logic [NC-1:0]     capture_ovf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [AW-1:0]    m_acc;
  logic [IW+FW-1:0] m_inc;
  logic [TW-1:0]    m_data [NC];
  logic             m_valid[NC];
  logic             m_ovf  [NC];

  stamp_counter_multi #(
    .TIMESTAMP_WIDTH(TW),
    .FRAC_WIDTH     (FW),
    .INC_INT_WIDTH  (IW),
    .INC_DEFAULT    (32'd10 << 24),
    .NUM_CHAN       (NC)
  ) dut (
    .axi_aclk     (axi_aclk),
    .axi_reset    (axi_reset),
    .count_en     (count_en),
    .inc_valid    (inc_valid),
    .inc_value    (inc_value),
    .load_valid   (load_valid),
    .load_value   (load_value),
    .adj_valid    (adj_valid),
    .adj_value    (adj_value),
    .capture_req  (capture_req),
    .capture_ack  (capture_ack),
    .stamp_counter(stamp_counter),
    .capture_data (capture_data),
    .capture_valid(capture_valid),
    .capture_ovf  (capture_ovf)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] chan_data(input int i);
    return capture_data[i*TW +: TW];
  endfunction

  function automatic logic [TW-1:0] model_stamp();
    return TW'(m_acc >> FW);
  endfunction

  // Applies the spec rules for one clock edge to the model.
  task automatic model_edge();
    logic [TW-1:0]        old_stamp;
    logic signed [AW-1:0] adj_s;
    old_stamp = model_stamp();
    if (axi_reset) begin
      m_acc = '0;
      m_inc = 32'd10 * (32'd1 << FW);
      for (int i = 0; i < NC; i++) begin
        m_data[i] = '0; m_valid[i] = 1'b0; m_ovf[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (!m_valid[i]) begin
          if (capture_req[i]) begin
            m_data[i] = old_stamp; m_valid[i] = 1'b1; m_ovf[i] = 1'b0;
          end else if (capture_ack[i]) m_ovf[i] = 1'b0;
        end else begin
          if (capture_ack[i] && !capture_req[i]) begin
            m_valid[i] = 1'b0; m_ovf[i] = 1'b0;
          end else if (capture_req[i] && !capture_ack[i]) m_ovf[i] = 1'b1;
          else if (capture_req[i] && capture_ack[i]) begin
            m_data[i] = old_stamp; m_ovf[i] = 1'b0;
          end
        end
      end
      if (load_valid) m_acc = AW'(load_value) * (AW'(1) << FW);
      else begin
        adj_s = $signed(adj_value);
        adj_s = adj_s * 16777216;
        if (count_en)  m_acc = m_acc + AW'(m_inc);
        if (adj_valid) m_acc = m_acc + adj_s;
      end
      if (inc_valid) m_inc = inc_value;
    end
  endtask

  task automatic compare_all();
    check("stamp", stamp_counter, model_stamp());
    for (int i = 0; i < NC; i++) begin
      check($sformatf("data%0d", i), chan_data(i), m_data[i]);
      check($sformatf("valid%0d", i), TW'(capture_valid[i]), TW'(m_valid[i]));
      check($sformatf("ovf%0d", i), TW'(capture_ovf[i]), TW'(m_ovf[i]));
    end
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later,
  // then all one-cycle strobes drop.
  task automatic step();
    @(posedge axi_aclk);
    model_edge();
    #1;
    compare_all();
    axi_reset   = 1'b0;
    load_valid  = 1'b0;
    inc_valid   = 1'b0;
    adj_valid   = 1'b0;
    capture_req = '0;
    capture_ack = '0;
  endtask

  initial begin
    logic [TW-1:0] frac_exp [4];
    frac_exp = '{64'd10, 64'd21, 64'd31, 64'd42};
    m_acc = '0; m_inc = '0;
    for (int i = 0; i < NC; i++) begin
      m_data[i] = '0; m_valid[i] = 1'b0; m_ovf[i] = 1'b0;
    end
    axi_reset = 1'b1; count_en = 1'b1; inc_valid = 1'b0; inc_value = '0;
    load_valid = 1'b0; load_value = '0; adj_valid = 1'b0; adj_value = '0;
    capture_req = '0; capture_ack = '0;

    // Reset state and default increment
    step();
    check("reset_stamp", stamp_counter, 64'd0);
    check("reset_valid", TW'(capture_valid), 64'd0);
    check("reset_data", capture_data[TW-1:0] | capture_data[NC*TW-1 -: TW], 64'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("default_inc", stamp_counter, 64'(10 * k));
    end
    check("idle_valid", TW'(capture_valid), 64'd0);

    // 10.5 ns increment; load and inc strobe together
    load_valid = 1'b1; load_value = '0; inc_valid = 1'b1; inc_value = 32'h0A80_0000;
    step();
    check("load_zero", stamp_counter, 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("frac_inc", stamp_counter, frac_exp[k]);
    end

    // Wrap through zero
    inc_valid = 1'b1; inc_value = 32'h0A00_0000;
    load_valid = 1'b1; load_value = 64'hFFFF_FFFF_FFFF_FFF6;
    step();
    check("load_near_wrap", stamp_counter, 64'hFFFF_FFFF_FFFF_FFF6);
    step();
    check("wrap_zero", stamp_counter, 64'd0);
    step();
    check("wrap_ten", stamp_counter, 64'd10);

    // Load beats adjust and increment
    load_valid = 1'b1; load_value = 64'h1234; adj_valid = 1'b1; adj_value = 64'd100;
    step();
    check("load_over_adj", stamp_counter, 64'h1234);

    // Negative adjust with and without counting
    load_valid = 1'b1; load_value = 64'd100;
    step();
    adj_valid = 1'b1; adj_value = -64'sd5;
    step();
    check("adj_count", stamp_counter, 64'd105);
    count_en = 1'b0; load_valid = 1'b1; load_value = 64'd100;
    step();
    adj_valid = 1'b1; adj_value = -64'sd5;
    step();
    check("adj_hold", stamp_counter, 64'd95);

    // Channel 2: capture, overflow, ack
    count_en = 1'b1; load_valid = 1'b1; load_value = 64'd40;
    step();
    capture_req = 4'b0100;
    step();
    check("ch2_data", chan_data(2), 64'd40);
    check("ch2_valid", TW'(capture_valid[2]), 64'd1);
    step();
    check("ch2_stamp60", stamp_counter, 64'd60);
    capture_req = 4'b0100;
    step();
    check("ch2_keep", chan_data(2), 64'd40);
    check("ch2_ovf", TW'(capture_ovf[2]), 64'd1);
    capture_ack = 4'b0100;
    step();
    check("ch2_ack_valid", TW'(capture_valid[2]), 64'd0);
    check("ch2_ack_ovf", TW'(capture_ovf[2]), 64'd0);
    check("ch2_ack_data", chan_data(2), 64'd40);

    // Channel 0: simultaneous req and ack while full
    capture_req = 4'b0001;
    step();
    load_valid = 1'b1; load_value = 64'd200;
    step();
    capture_req = 4'b0001; capture_ack = 4'b0001;
    step();
    check("ch0_data", chan_data(0), 64'd200);
    check("ch0_valid", TW'(capture_valid[0]), 64'd1);
    check("ch0_ovf", TW'(capture_ovf[0]), 64'd0);
    check("ch1_data", chan_data(1), 64'd0);
    check("ch1_flags", TW'({capture_valid[1], capture_ovf[1]}), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      axi_reset = ($urandom_range(0, 99) == 0);
      count_en  = ($urandom_range(0, 7) != 0);
      inc_valid = ($urandom_range(0, 15) == 0);
      inc_value = $urandom_range(0, 32'h1400_0000);
      load_valid = ($urandom_range(0, 15) == 0);
      load_value = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                                : 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      adj_valid = ($urandom_range(0, 7) == 0);
      adj_value = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                               : 64'($signed(32'($urandom_range(0, 200)) - 32'sd100));
      capture_req = NC'($urandom) & NC'($urandom);
      capture_ack = NC'($urandom) & NC'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stamp_counter_multi.md
Name: stamp_counter_multi

Overview:
- Next-generation free-running timestamp source for the NetFPGA-10G datapath.
- Replaces the fixed +1 counter with a fractional-ns accumulator. The increment is programmable, so software can correct drift.
- Supports an atomic load and a signed one-shot adjust.
- Provides NUM_CHAN independent capture channels, so ports and PPS can latch the current stamp.
- Sits beside the AXI-Lite register block; register fields drive its control inputs.

Parameters:
TIMESTAMP_WIDTH, 64, integer width of the stamp (ns units)
FRAC_WIDTH, 24, fractional bits of the accumulator
INC_INT_WIDTH, 8, integer bits of the increment
INC_DEFAULT, 10<<24, increment applied after reset (10 ns per cycle at 100 MHz)
NUM_CHAN, 4, number of capture channels (1..16)

Ports:
axi_aclk  in  1  sole clock
axi_reset  in  1  synchronous, active-high reset
count_en  in  1  1 = accumulate each cycle; 0 = hold
inc_valid  in  1  one-cycle strobe: take inc_value
inc_value  in  INC_INT_WIDTH+FRAC_WIDTH  unsigned fixed-point increment per cycle
load_valid  in  1  one-cycle strobe: set stamp
load_value  in  TIMESTAMP_WIDTH  new integer stamp
adj_valid  in  1  one-cycle strobe: add offset
adj_value  in  TIMESTAMP_WIDTH  two's-complement signed offset (ns)
capture_req  in  NUM_CHAN  per-channel capture pulse (synchronous to axi_aclk)
capture_ack  in  NUM_CHAN  per-channel read acknowledge
stamp_counter  out  TIMESTAMP_WIDTH  current integer stamp
capture_data  out  NUM_CHAN*TIMESTAMP_WIDTH  latched stamps; channel i occupies [i*TW +: TW]
capture_valid  out  NUM_CHAN  channel holds unread data
capture_ovf  out  NUM_CHAN  sticky: request lost while valid

Behaviour:
- Reset (axi_reset=1 at a clock edge):
  - accumulator (integer and fraction) = 0; inc_reg = INC_DEFAULT.
  - stamp_counter = 0; all capture_data = 0, capture_valid = 0, capture_ovf = 0.
  - Reset overrides every other input in that cycle.
- Accumulator {int, frac}, width TIMESTAMP_WIDTH+FRAC_WIDTH. stamp_counter = int part, registered directly (no extra pipeline).
- Per-cycle update, highest priority first:
  1. load_valid: int = load_value, frac = 0. This cycle's increment and any adj are discarded.
  2. Otherwise next = acc + (count_en ? inc_reg : 0) + (adj_valid ? sign-extended adj_value << FRAC_WIDTH : 0).
- Load latency: load at edge N gives stamp_counter = load_value after N. The increment resumes from the following edge.
- Adjust: takes effect at the same edge; the increment is still applied that cycle when count_en = 1.
- Arithmetic is modulo 2^(TIMESTAMP_WIDTH+FRAC_WIDTH). Wrap from all-ones to 0 is silent; no flag.
- inc_valid updates inc_reg at edge N. The new increment is first used at edge N+1. inc_value = 0 is legal (counter frozen).
- Capture channel i (identical, independent per channel):
  - State IDLE (valid=0): on req, data = stamp_counter as sampled at that edge (the pre-update value), valid = 1. Capture latency is 1 cycle.
  - State FULL (valid=1):
    - ack without req → valid = 0, ovf = 0. Data is retained.
    - req without ack → data unchanged (first capture wins), ovf = 1.
    - req and ack together → new data captured, valid stays 1, ovf = 0.
  - ack while IDLE: no effect (clears ovf if set).
- Load/adjust never modify already captured data.
- Reset mid-capture: all channels return to IDLE with zeroed data.

Decomposition:
- Shared header stamp_defs: default increment, max NUM_CHAN, accumulator width macro.
- Sub-module stamp_capture_chan: one capture channel (IDLE/FULL plus ovf), instantiated NUM_CHAN times by generate.
- Top module: accumulator, inc_reg, priority logic.

Test Plan:
- Reset, count_en=1, default increment, 5 cycles → stamp_counter steps 0,10,20,30,40,50. Capture outputs stay 0.
- inc_value = 0x0A800000 (10.5 ns), 4 cycles from 0 → 10, 21, 31, 42 (fraction carries).
- load_value = 0xFFFF_FFFF_FFFF_FFF6 with default increment → next edge 0, then 10 (wrap). Load and adj = 100 asserted together → stamp = load_value exactly.
- adj_value = -5 at stamp 100, count_en = 1 → 105. Same with count_en = 0 → 95.
- Channel 2: req at stamp 40 → data 40, valid = 1. Req at 60 without ack → data 40, ovf = 1. Ack → valid = 0, ovf = 0.
- Channel 0: req and ack together while FULL at stamp 200 → data 200, valid = 1, ovf = 0. Channel 1 untouched throughout.
